// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing the register-file write port
// between three writeback sources (0 = ALU, 1 = load, 2 = immediate/move).
// All outputs are registered. Optional feature macro: REG0_PROTECT_EN
// (when defined, grants targeting register 0 never raise RF_WE).
module reg_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  REQ2,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [ADDR_WIDTH-1:0] ADDR2,
  input  logic [DATA_WIDTH-1:0] DATA0,
  input  logic [DATA_WIDTH-1:0] DATA1,
  input  logic [DATA_WIDTH-1:0] DATA2,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  GNT2,
  output logic                  RF_WE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_DATA,
  output logic [7:0]            WR_CNT,
  output logic                  BUSY
);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              gnt_q, gnt_d;
  logic [1:0]              last_q, last_d;
  logic                    rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_data_q, rf_data_d;
  logic [7:0]              wr_cnt_q, wr_cnt_d;
  logic                    busy_q, busy_d;

  logic [2:0]              req;
  logic [2:0]              mask;
  logic [2:0]              unmasked;
  logic [5:0]              order;   // three 2-bit source indices, [1:0] searched first
  logic                    found;
  logic [1:0]              win;
  logic [1:0]              cand;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    wr_en;

  // Arbitration, data select and next-state computation.
  always_comb begin
    req      = {REQ2, REQ1, REQ0};
    // The source being granted this cycle is excluded so one transaction is never granted twice.
    mask     = (state_q == StWrite) ? gnt_q : 3'b000;
    unmasked = req & ~mask;

    // Search order LAST+1, LAST+2, LAST+3 (mod 3).
    unique case (last_q)
      2'd0:    order = {2'd0, 2'd2, 2'd1};
      2'd1:    order = {2'd1, 2'd0, 2'd2};
      default: order = {2'd2, 2'd1, 2'd0};
    endcase

    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand = order[2*k +: 2];
      if (!found && unmasked[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    unique case (win)
      2'd1: begin
        sel_addr = ADDR1;
        sel_data = DATA1;
      end
      2'd2: begin
        sel_addr = ADDR2;
        sel_data = DATA2;
      end
      default: begin
        sel_addr = ADDR0;
        sel_data = DATA0;
      end
    endcase

`ifdef REG0_PROTECT_EN
    // Register 0 is hard-wired to zero: acknowledge the write but never enable it.
    wr_en = (sel_addr != '0);
`else
    wr_en = 1'b1;
`endif

    state_d   = StIdle;
    gnt_d     = 3'b000;
    last_d    = last_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    wr_cnt_d  = wr_cnt_q;
    busy_d    = |unmasked;

    if (found) begin
      state_d   = StWrite;
      gnt_d     = 3'b001 << win;
      last_d    = win;
      rf_we_d   = wr_en;
      rf_addr_d = sel_addr;
      rf_data_d = sel_data;
      wr_cnt_d  = wr_cnt_q + 8'd1;
    end
  end

  // State and output registers; reset clears everything without waiting for CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      gnt_q     <= 3'b000;
      last_q    <= 2'd2;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      wr_cnt_q  <= 8'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      wr_cnt_q  <= wr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign GNT0    = gnt_q[0];
  assign GNT1    = gnt_q[1];
  assign GNT2    = gnt_q[2];
  assign RF_WE   = rf_we_q;
  assign RF_ADDR = rf_addr_q;
  assign RF_DATA = rf_data_q;
  assign WR_CNT  = wr_cnt_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model. Honors REG0_PROTECT_EN.
module tb_reg_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, REQ1, REQ2;
  logic [AW-1:0] ADDR0, ADDR1, ADDR2;
  logic [DW-1:0] DATA0, DATA1, DATA2;
  logic          GNT0, GNT1, GNT2;
  logic          RF_WE;
  logic [AW-1:0] RF_ADDR;
  logic [DW-1:0] RF_DATA;
  logic [7:0]    WR_CNT;
  logic          BUSY;

  int n_cmp = 0;
  int n_err = 0;

  reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .REQ2(REQ2),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .ADDR2(ADDR2),
    .DATA0(DATA0), .DATA1(DATA1), .DATA2(DATA2),
    .GNT0(GNT0), .GNT1(GNT1), .GNT2(GNT2),
    .RF_WE(RF_WE), .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA),
    .WR_CNT(WR_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    REQ0 = 0; REQ1 = 0; REQ2 = 0;
    ADDR0 = '0; ADDR1 = '0; ADDR2 = '0;
    DATA0 = '0; DATA1 = '0; DATA2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] g;
    do_reset();
    g = {GNT2, GNT1, GNT0};
    n_cmp++; if (g !== 3'b000) begin n_err++; $display("FAIL reset_gnt got %b want 000", g); end
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", RF_WE); end
    n_cmp++; if (RF_ADDR !== '0) begin n_err++; $display("FAIL reset_addr got %0d want 0", RF_ADDR); end
    n_cmp++; if (RF_DATA !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", RF_DATA); end
    n_cmp++; if (WR_CNT !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", WR_CNT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", BUSY); end
  endtask

  task automatic test_single_write();
    do_reset();
    REQ0 = 1; ADDR0 = 5'd3; DATA0 = 32'h0000_00AA;
    tick();
    n_cmp++; if (GNT0 !== 1'b1) begin n_err++; $display("FAIL single_gnt0 got %b want 1", GNT0); end
    n_cmp++; if (RF_WE !== 1'b1) begin n_err++; $display("FAIL single_we got %b want 1", RF_WE); end
    n_cmp++; if (RF_ADDR !== 5'd3) begin n_err++; $display("FAIL single_addr got %0d want 3", RF_ADDR); end
    n_cmp++; if (RF_DATA !== 32'hAA) begin n_err++; $display("FAIL single_data got %h want aa", RF_DATA); end
    n_cmp++; if (WR_CNT !== 8'd1) begin n_err++; $display("FAIL single_cnt got %0d want 1", WR_CNT); end
    tick();  // REQ0 still high at the masking edge
    n_cmp++; if (GNT0 !== 1'b0) begin n_err++; $display("FAIL single_masked got %b want 0", GNT0); end
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL single_masked_we got %b want 0", RF_WE); end
    n_cmp++; if (RF_ADDR !== 5'd3) begin n_err++; $display("FAIL single_hold_addr got %0d want 3", RF_ADDR); end
    REQ0 = 0;
  endtask

  task automatic test_all_three();
    logic [2:0] g;
    logic [2:0] exp_g;
    do_reset();
    REQ0 = 1; REQ1 = 1; REQ2 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      g = {GNT2, GNT1, GNT0};
      exp_g = 3'b001 << (i % 3);
      n_cmp++; if (g !== exp_g) begin n_err++; $display("FAIL rr3_gnt[%0d] got %b want %b", i, g, exp_g); end
      n_cmp++; if (RF_WE !== 1'b1) begin n_err++; $display("FAIL rr3_we[%0d] got %b want 1", i, RF_WE); end
    end
    n_cmp++; if (WR_CNT !== 8'd6) begin n_err++; $display("FAIL rr3_cnt got %0d want 6", WR_CNT); end
    idle_inputs();
  endtask

  task automatic test_only_req1();
    logic exp_g;
    do_reset();
    REQ1 = 1; ADDR1 = 5'd9; DATA1 = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_g = (i % 2 == 0);
      n_cmp++; if (GNT1 !== exp_g) begin n_err++; $display("FAIL req1_gnt[%0d] got %b want %b", i, GNT1, exp_g); end
    end
    n_cmp++; if (WR_CNT !== 8'd3) begin n_err++; $display("FAIL req1_cnt got %0d want 3", WR_CNT); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    REQ2 = 1; ADDR2 = 5'd17; DATA2 = 32'hCAFE_0002;
    tick();
    n_cmp++; if (GNT2 !== 1'b1) begin n_err++; $display("FAIL arst_pre_gnt2 got %b want 1", GNT2); end
    #2 RST = 1'b1;  // mid-cycle, away from any edge
    #1;
    n_cmp++; if (GNT2 !== 1'b0) begin n_err++; $display("FAIL arst_gnt2 got %b want 0", GNT2); end
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL arst_we got %b want 0", RF_WE); end
    n_cmp++; if (WR_CNT !== 8'd0) begin n_err++; $display("FAIL arst_cnt got %0d want 0", WR_CNT); end
    #2 RST = 1'b0;
    tick();
    n_cmp++; if (GNT2 !== 1'b1) begin n_err++; $display("FAIL arst_regrant got %b want 1", GNT2); end
    n_cmp++; if (WR_CNT !== 8'd1) begin n_err++; $display("FAIL arst_regrant_cnt got %0d want 1", WR_CNT); end
    idle_inputs();
  endtask

  task automatic test_reg0();
    do_reset();
    REQ0 = 1; ADDR0 = 5'd0; DATA0 = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (GNT0 !== 1'b1) begin n_err++; $display("FAIL reg0_gnt got %b want 1", GNT0); end
    n_cmp++; if (WR_CNT !== 8'd1) begin n_err++; $display("FAIL reg0_cnt got %0d want 1", WR_CNT); end
`ifdef REG0_PROTECT_EN
    n_cmp++; if (RF_WE !== 1'b0) begin n_err++; $display("FAIL reg0_we got %b want 0", RF_WE); end
`else
    n_cmp++; if (RF_WE !== 1'b1) begin n_err++; $display("FAIL reg0_we got %b want 1", RF_WE); end
    n_cmp++; if (RF_ADDR !== 5'd0) begin n_err++; $display("FAIL reg0_addr got %0d want 0", RF_ADDR); end
`endif
    idle_inputs();
  endtask

  task automatic test_wrap();
    int c0, c1;
    c0 = 0; c1 = 0;
    do_reset();
    REQ0 = 1; REQ1 = 1;
    for (int i = 0; i < 512; i++) begin
      tick();
      c0 += int'(GNT0);
      c1 += int'(GNT1);
      if (i == 255) begin
        n_cmp++; if (WR_CNT !== 8'd0) begin n_err++; $display("FAIL wrap_256 got %0d want 0", WR_CNT); end
      end
    end
    n_cmp++; if (WR_CNT !== 8'd0) begin n_err++; $display("FAIL wrap_512 got %0d want 0", WR_CNT); end
    n_cmp++; if (c0 !== 256) begin n_err++; $display("FAIL wrap_src0 got %0d want 256", c0); end
    n_cmp++; if (c1 !== 256) begin n_err++; $display("FAIL wrap_src1 got %0d want 256", c1); end
    idle_inputs();
  endtask

  // Randomized traffic against a spec-level model: round-robin from the last winner,
  // skipping the source that holds the grant in the current cycle.
  task automatic test_random();
    int            m_last, m_gnt, m_cnt, found, idx;
    logic          m_we, m_busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [2:0]    req_v, g, exp_g;
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    do_reset();
    m_last = 2; m_gnt = -1; m_cnt = 0; m_we = 0; m_busy = 0; m_addr = '0; m_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      REQ0 = ($urandom_range(0, 9) < 6); REQ1 = ($urandom_range(0, 9) < 6);
      REQ2 = ($urandom_range(0, 9) < 6);
      ADDR0 = AW'($urandom_range(0, 31)); ADDR1 = AW'($urandom_range(0, 31));
      ADDR2 = AW'($urandom_range(0, 31));
      DATA0 = $urandom; DATA1 = $urandom; DATA2 = $urandom;
      req_v = {REQ2, REQ1, REQ0};
      a[0] = ADDR0; a[1] = ADDR1; a[2] = ADDR2;
      d[0] = DATA0; d[1] = DATA1; d[2] = DATA2;
      found = -1;
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (found < 0 && req_v[idx] && idx != m_gnt) found = idx;
      end
      m_busy = (found >= 0);
      if (found >= 0) begin
        m_gnt = found; m_last = found;
        m_addr = a[found]; m_data = d[found];
        m_cnt = (m_cnt + 1) % 256;
`ifdef REG0_PROTECT_EN
        m_we = (a[found] != 0);
`else
        m_we = 1'b1;
`endif
      end else begin
        m_gnt = -1; m_we = 1'b0;
      end
      tick();
      g = {GNT2, GNT1, GNT0};
      exp_g = (m_gnt < 0) ? 3'b000 : (3'b001 << m_gnt);
      n_cmp++; if (g !== exp_g) begin n_err++; $display("FAIL rnd_gnt[%0d] got %b want %b", cyc, g, exp_g); end
      n_cmp++; if (RF_WE !== m_we) begin n_err++; $display("FAIL rnd_we[%0d] got %b want %b", cyc, RF_WE, m_we); end
      n_cmp++; if (RF_ADDR !== m_addr) begin n_err++; $display("FAIL rnd_addr[%0d] got %0d want %0d", cyc, RF_ADDR, m_addr); end
      n_cmp++; if (RF_DATA !== m_data) begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", cyc, RF_DATA, m_data); end
      n_cmp++; if (WR_CNT !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", cyc, WR_CNT, m_cnt); end
      n_cmp++; if (BUSY !== m_busy) begin n_err++; $display("FAIL rnd_busy[%0d] got %b want %b", cyc, BUSY, m_busy); end
    end
    idle_inputs();
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_all_three();
    test_only_req1();
    test_async_reset();
    test_reg0();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares the single write port of the register file between three writeback sources: 0 = ALU result, 1 = memory load, 2 = immediate/move. Each source raises a request with a destination address and data. The arbiter grants one source per cycle and drives registered write-enable, address and data straight into the register file. It sits between the execute/memory stages and the register file and is the only block allowed to drive the register file's WE.

## Interface
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, width of register address.

- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ0 / REQ1 / REQ2  input  1 each  write request from source 0/1/2.
- ADDR0 / ADDR1 / ADDR2  input  ADDR_WIDTH each  destination register of source n.
- DATA0 / DATA1 / DATA2  input  DATA_WIDTH each  write data of source n.
- GNT0 / GNT1 / GNT2  output  1 each  one-cycle grant/acknowledge to source n.
- RF_WE  output  1  register-file write enable.
- RF_ADDR  output  ADDR_WIDTH  register-file write address.
- RF_DATA  output  DATA_WIDTH  register-file write data.
- WR_CNT  output  8  count of completed grants, wraps 255 -> 0.
- BUSY  output  1  high when any unmasked request was pending at the last edge.

## Operation
- Handshake: a source raises REQn and holds ADDRn/DATAn stable until it sees GNTn high. It must deassert REQn, or present a new transaction, no earlier than the edge that ends the GNTn cycle.
- Arbitration runs at each rising edge over the unmasked requests. The source granted in the current cycle (GNTn = 1) is masked at that edge, so the arbiter never double-grants one transaction.
- Round-robin pointer LAST (2 bits) holds the index of the last granted source. The search order is LAST+1, LAST+2, LAST+3 modulo 3. LAST updates only on a grant.
- On a grant to source n, the next cycle has GNTn = 1, RF_WE = 1, RF_ADDR = ADDRn and RF_DATA = DATAn (captured at the edge), and WR_CNT increments by 1.
- With no unmasked request, the next cycle has all GNT = 0 and RF_WE = 0. RF_ADDR and RF_DATA hold their previous values.
- At most one GNT is high in any cycle. RF_WE equals the OR of the GNTs, except as noted under Configuration.
- Implicit two-state FSM: IDLE (no grant this cycle) and WRITE (grant this cycle).
  - IDLE -> WRITE on any unmasked request.
  - WRITE -> WRITE on another unmasked request.
  - otherwise -> IDLE.
- Simultaneous requests: exactly one source wins per edge and the losers stay pending. Under continuous contention, each of three sources is served within 3 cycles.
- Only one source requesting: a continuously held REQ is served every other cycle, because of the mask.

## Timing
- Reset values: GNT0-2 = 0, RF_WE = 0, RF_ADDR = 0, RF_DATA = 0, WR_CNT = 0, BUSY = 0, LAST = 2 (source 0 has top priority first), state IDLE.
- Latency: REQ sampled at edge k gives GNT/RF_WE high from edge k to edge k+1. All outputs are registered; there is no combinational input-to-output path.
- Throughput: one write per cycle with two or more sources active.
- RST asserted mid-WRITE: all outputs clear immediately, without waiting for CLK. The in-flight write is cut short and WR_CNT does not keep it. A source whose REQ is still high after RST falls is re-arbitrated from the reset pointer.
- WR_CNT wrap: 255 + 1 = 0, with no flag.

## Configuration
- REG0_PROTECT_EN defined: a grant whose ADDR equals 0 still pulses GNTn and increments WR_CNT, but RF_WE stays 0 for that cycle. This keeps register 0 hard-wired to zero.
- REG0_PROTECT_EN undefined: address 0 is written like any other register.

## Test plan
- Reset, then REQ0 = 1, ADDR0 = 3, DATA0 = 0x0000_00AA -> one cycle later GNT0 = 1, RF_WE = 1, RF_ADDR = 3, RF_DATA = 0xAA, WR_CNT = 1. The next cycle has GNT0 = 0 even though REQ0 is still high at the masking edge.
- REQ0, REQ1, REQ2 all held high from reset -> grants in order 0, 1, 2, 0, 1, 2 on consecutive cycles, RF_WE continuously 1, WR_CNT = 6 after six cycles.
- Only REQ1 held high for 6 cycles -> GNT1 pattern 1, 0, 1, 0, 1, 0 and WR_CNT = 3.
- RST pulsed asynchronously (mid-cycle) while GNT2 = 1 -> GNT2, RF_WE and WR_CNT go to 0 before the next CLK edge. After release, with REQ2 still high, GNT2 returns 1 cycle after the first edge.
- REQ0 with ADDR0 = 0, DATA0 = 0xFFFF_FFFF:
  - with REG0_PROTECT_EN defined -> GNT0 = 1, RF_WE = 0, WR_CNT = 1.
  - without it -> RF_WE = 1, RF_ADDR = 0.
- Hold REQ0 and REQ1 for 512 cycles -> WR_CNT wraps to 0 at 256 grants, and each source receives exactly 256 grants.
